// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared FSM state type and frame arithmetic for the serial receiver
package ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAR,
    STOP,
    BREAK
  } ser_state_e;

  // Bits on the line per frame: start + data + optional parity + stop.
  function automatic int frame_len(input int dw, input int parity_en);
    return dw + parity_en + 2;
  endfunction

endpackage

// File: rtl/ser_rx_shreg.sv
// rtl/ser_rx_shreg.sv - payload shift register, bit counter and running parity
module ser_rx_shreg
  import ser_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          shift,
  input  logic          acc,
  input  logic          din,
  output logic [DW-1:0] q,
  output logic          last,
  output logic          par
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic [CW-1:0] cnt;

  // acc folds the parity bit into the running XOR without shifting the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
      par <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      par <= 1'b0;
    end else if (shift) begin
      q   <= {din, q[DW-1:1]};
      cnt <= cnt + 1'b1;
      par <= par ^ din;
    end else if (acc) begin
      par <= par ^ din;
    end
  end

  assign last = (cnt == CW'(DW - 1));

endmodule

// File: rtl/ser_rx.sv
// rtl/ser_rx.sv - serial frame receiver with parity/stop checking and a one-deep holding register
module ser_rx
  import ser_pkg::*;
#(
  parameter int DW        = 8,
  parameter int PARITY_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sdi,
  output logic [DW-1:0] data,
  output logic          valid,
  input  logic          ready,
  output logic          perr,
  output logic          ferr,
  output logic          ovr
);

  ser_state_e    state, state_nx;
  logic          sdi_q;
  logic          sh_clr, sh_shift, sh_acc, sh_last, sh_par;
  logic [DW-1:0] sh_q;
  logic          done;
  logic          par_bad;

  // Line idles high, so the input flop resets to 1 to avoid a phantom start bit.
  always_ff @(posedge clk) begin
    if (rst) sdi_q <= 1'b1;
    else     sdi_q <= sdi;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sh_clr   = 1'b0;
    sh_shift = 1'b0;
    sh_acc   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (!sdi_q) begin
          state_nx = DATA;
          sh_clr   = 1'b1;
        end
      end
      DATA: begin
        sh_shift = 1'b1;
        if (sh_last) state_nx = (PARITY_EN != 0) ? PAR : STOP;
      end
      PAR: begin
        sh_acc   = 1'b1;
        state_nx = STOP;
      end
      STOP: begin
        done     = 1'b1;
        state_nx = sdi_q ? IDLE : BREAK;
      end
      BREAK: begin
        if (sdi_q) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  ser_rx_shreg #(.DW(DW)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .clr   (sh_clr),
    .shift (sh_shift),
    .acc   (sh_acc),
    .din   (sdi_q),
    .q     (sh_q),
    .last  (sh_last),
    .par   (sh_par)
  );

  assign par_bad = (PARITY_EN != 0) ? sh_par : 1'b0;

  // A completing frame replaces the held one only if the slot is empty or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else if (done) begin
      if (!valid || ready) begin
        data  <= sh_q;
        perr  <= par_bad;
        ferr  <= ~sdi_q;
        valid <= 1'b1;
      end else begin
        ovr <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ser_rx.sv
// tb/tb_ser_rx.sv - self-checking bench for ser_rx against a frame-level reference model
module tb_ser_rx;
  import ser_pkg::*;

  localparam int DW = 8;
  localparam int PE = 1;

  logic          clk;
  logic          rst;
  logic          sdi;
  logic          ready;
  logic [DW-1:0] data;
  logic          valid;
  logic          perr;
  logic          ferr;
  logic          ovr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
    int            en;
  } xfer_t;

  xfer_t got[$];

  ser_rx #(.DW(DW), .PARITY_EN(PE)) dut (
    .clk   (clk),
    .rst   (rst),
    .sdi   (sdi),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .perr  (perr),
    .ferr  (ferr),
    .ovr   (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every accepted frame together with the edge after which it was first visible.
  always @(negedge clk) begin
    if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1)
      got.push_back('{d: data, pe: perr, fe: ferr, en: cyc});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    sdi = b;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sdi = 1'b1;
    tick();
    rst = 1'b0;
    got.delete();
  endtask

  // cedge is the edge after which the frame must be visible on valid.
  task automatic send_frame(input logic [DW-1:0] d, input bit par_ok, input bit stop, output int cedge);
    logic pb;
    cedge = cyc + 1 + frame_len(DW, PE);
    pb = (^d) ^ ~par_ok;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (PE != 0) drive_bit(pb);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    sdi   = 1'b0;
    ready = 1'b0;
    tick();
    sdi = 1'b1;
    tick();
    rst = 1'b0;
    got.delete();
    checks++; if (data !== '0)    begin failures++; $display("FAIL reset_data: got %0h expected 0", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (perr !== 1'b0)  begin failures++; $display("FAIL reset_perr: got %b expected 0", perr); end
    checks++; if (ferr !== 1'b0)  begin failures++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
    checks++; if (ovr !== 1'b0)   begin failures++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
    ready = 1'b1;
    repeat (20) drive_bit(1'b1);
    checks++; if (got.size() != 0) begin failures++; $display("FAIL reset_no_false_start: got %0d frames expected 0", got.size()); end
  endtask

  task automatic test_nominal();
    int ce;
    do_reset();
    ready = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b1, ce);
    repeat (15) drive_bit(1'b1);
    checks++;
    if (got.size() != 1 || got[0].d !== 8'h3C || got[0].pe !== 1'b0 || got[0].fe !== 1'b0 || got[0].en != ce) begin
      failures++;
      $display("FAIL nominal: got n=%0d d=%0h pe=%b fe=%b edge=%0d expected n=1 d=3c pe=0 fe=0 edge=%0d",
               got.size(), got[0].d, got[0].pe, got[0].fe, got[0].en, ce);
    end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL nominal_valid_clear: got %b expected 0", valid); end
  endtask

  task automatic test_parity();
    int ce;
    do_reset();
    ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, ce);
    repeat (15) drive_bit(1'b1);
    checks++;
    if (got.size() != 1 || got[0].d !== 8'hA5 || got[0].pe !== 1'b1 || got[0].fe !== 1'b0) begin
      failures++;
      $display("FAIL parity_err: got n=%0d d=%0h pe=%b fe=%b expected n=1 d=a5 pe=1 fe=0",
               got.size(), got[0].d, got[0].pe, got[0].fe);
    end
  endtask

  task automatic test_framing();
    int ce1, ce2;
    do_reset();
    ready = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0, ce1);
    repeat (3) drive_bit(1'b0);
    drive_bit(1'b1);
    checks++; if (got.size() != 1) begin failures++; $display("FAIL framing_break_frames: got %0d expected 1", got.size()); end
    send_frame(8'h12, 1'b1, 1'b1, ce2);
    repeat (15) drive_bit(1'b1);
    checks++;
    if (got.size() != 2 || got[0].d !== 8'h55 || got[0].fe !== 1'b1 || got[0].pe !== 1'b0 || got[0].en != ce1) begin
      failures++;
      $display("FAIL framing_first: got n=%0d d=%0h pe=%b fe=%b edge=%0d expected n=2 d=55 pe=0 fe=1 edge=%0d",
               got.size(), got[0].d, got[0].pe, got[0].fe, got[0].en, ce1);
    end
    checks++;
    if (got[1].d !== 8'h12 || got[1].fe !== 1'b0 || got[1].pe !== 1'b0 || got[1].en != ce2) begin
      failures++;
      $display("FAIL framing_second: got d=%0h pe=%b fe=%b edge=%0d expected d=12 pe=0 fe=0 edge=%0d",
               got[1].d, got[1].pe, got[1].fe, got[1].en, ce2);
    end
  endtask

  task automatic test_overrun();
    int ce;
    do_reset();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, ce);
    send_frame(8'h22, 1'b1, 1'b1, ce);
    repeat (3) drive_bit(1'b1);
    checks++;
    if (valid !== 1'b1 || data !== 8'h11 || ovr !== 1'b1) begin
      failures++;
      $display("FAIL overrun_hold: got valid=%b data=%0h ovr=%b expected valid=1 data=11 ovr=1", valid, data, ovr);
    end
    ready = 1'b1;
    repeat (5) drive_bit(1'b1);
    checks++;
    if (got.size() != 1 || got[0].d !== 8'h11 || valid !== 1'b0 || ovr !== 1'b1) begin
      failures++;
      $display("FAIL overrun_drain: got n=%0d d=%0h valid=%b ovr=%b expected n=1 d=11 valid=0 ovr=1",
               got.size(), got[0].d, valid, ovr);
    end
    do_reset();
    checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL overrun_reset: got ovr=%b expected 0", ovr); end
  endtask

  task automatic test_simultaneous();
    int ca, cb;
    do_reset();
    ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b1, ca);
    send_frame(8'hC3, 1'b1, 1'b1, cb);
    ready = 1'b1;
    repeat (5) drive_bit(1'b1);
    checks++;
    if (got.size() != 2 || got[0].d !== 8'h5A || got[1].d !== 8'hC3 || got[1].en != cb) begin
      failures++;
      $display("FAIL simultaneous: got n=%0d d0=%0h d1=%0h edge1=%0d expected n=2 d0=5a d1=c3 edge1=%0d",
               got.size(), got[0].d, got[1].d, got[1].en, cb);
    end
    checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL simultaneous_ovr: got %b expected 0", ovr); end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    do_reset();
    ready = 1'b1;
    send_frame(8'h01, 1'b1, 1'b1, c1);
    send_frame(8'h80, 1'b1, 1'b1, c2);
    repeat (15) drive_bit(1'b1);
    checks++;
    if (got.size() != 2 || got[0].d !== 8'h01 || got[1].d !== 8'h80 || got[0].en != c1 || got[1].en - got[0].en != 11) begin
      failures++;
      $display("FAIL back_to_back: got n=%0d d0=%0h d1=%0h e0=%0d e1=%0d expected n=2 d0=01 d1=80 e0=%0d e1=%0d",
               got.size(), got[0].d, got[1].d, got[0].en, got[1].en, c1, c1 + 11);
    end
  endtask

  task automatic test_reset_mid();
    int ce;
    do_reset();
    ready = 1'b1;
    drive_bit(1'b0);
    repeat (4) drive_bit(1'b1);
    rst = 1'b1;
    drive_bit(1'b1);
    rst = 1'b0;
    repeat (2) drive_bit(1'b1);
    checks++; if (got.size() != 0 || valid !== 1'b0) begin failures++; $display("FAIL reset_mid_discard: got n=%0d valid=%b expected n=0 valid=0", got.size(), valid); end
    send_frame(8'h0F, 1'b1, 1'b1, ce);
    repeat (15) drive_bit(1'b1);
    checks++;
    if (got.size() != 1 || got[0].d !== 8'h0F || got[0].pe !== 1'b0 || got[0].fe !== 1'b0 || ovr !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_next: got n=%0d d=%0h pe=%b fe=%b ovr=%b expected n=1 d=0f pe=0 fe=0 ovr=0",
               got.size(), got[0].d, got[0].pe, got[0].fe, ovr);
    end
  endtask

  task automatic test_random();
    xfer_t         exp_q[$];
    logic [DW-1:0] d;
    bit            par_ok, stop;
    logic          pb;
    int            ce;
    do_reset();
    ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      d      = DW'($urandom);
      par_ok = ($urandom_range(0, 3) != 0);
      stop   = ($urandom_range(0, 4) != 0);
      pb     = (^d) ^ ~par_ok;
      send_frame(d, par_ok, stop, ce);
      exp_q.push_back('{d: d, pe: ^{d, pb}, fe: ~stop, en: ce});
      if (!stop) begin
        repeat ($urandom_range(0, 3)) drive_bit(1'b0);
        drive_bit(1'b1);
      end
      repeat ($urandom_range(0, 2)) drive_bit(1'b1);
    end
    repeat (15) drive_bit(1'b1);
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_count: got %0d expected %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].pe !== exp_q[i].pe || got[i].fe !== exp_q[i].fe || got[i].en != exp_q[i].en) begin
        failures++;
        $display("FAIL random_frame%0d: got d=%0h pe=%b fe=%b edge=%0d expected d=%0h pe=%b fe=%b edge=%0d",
                 i, got[i].d, got[i].pe, got[i].fe, got[i].en, exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].en);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    sdi   = 1'b1;
    ready = 1'b0;
    test_reset();
    test_nominal();
    test_parity();
    test_framing();
    test_overrun();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
